if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register.
- Holds the PC and drives a single-outstanding-request instruction memory interface.
- Registers the fetched word and its PC for decode, exporting instr[6:0] directly as the opcode feeding the control unit.
- Handles hazard-unit stall/flush and branch redirect from EX.

Parameters:
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word presented on bubbles (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address (= pc)
- imem_gnt_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  XLEN  response instruction word
- stall_i  in  1  hold IF/ID contents (load-use hazard)
- flush_i  in  1  squash IF/ID contents
- redirect_i  in  1  taken branch/jump
- redirect_pc_i  in  XLEN  branch target
- if_id_valid_o  out  1  IF/ID holds a real instruction
- if_id_pc_o  out  XLEN  PC of IF/ID instruction
- if_id_instr_o  out  XLEN  IF/ID instruction word
- if_id_opcode_o  out  7  if_id_instr_o[6:0], to control unit
- fetch_cnt_o  out  32  retired-fetch counter (see optional feature)
- bubble_cnt_o  out  32  bubble counter (see optional feature)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - pc=RESET_PC, state=REQ
  - if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=NOP_INSTR
  - hold buffer empty, counters 0
  - imem_req_o=0 while rst_n low.
- FSM states: REQ, WAIT, HOLD, DROP. At most one outstanding request.
- Request signals:
  - imem_req_o = (state==REQ) && !redirect_i; imem_addr_o = pc.
  - Request fires on imem_req_o && imem_gnt_i.
- REQ:
  - gnt -> WAIT.
  - redirect_i -> pc<=redirect_pc_i, stay REQ.
- WAIT:
  - redirect_i (with or without rvalid): discard data, pc<=redirect_pc_i. Go REQ if rvalid, else DROP.
  - rvalid && !stall_i: load IF/ID (valid=1, pc, rdata), pc<=pc+4, -> REQ.
  - rvalid && stall_i: capture {pc, rdata} into hold buffer, pc<=pc+4, -> HOLD.
- HOLD:
  - redirect_i: discard buffer, pc<=redirect_pc_i, -> REQ.
  - !stall_i: move buffer into IF/ID, -> REQ.
- DROP: on rvalid discard data -> REQ. redirect_i here updates pc again, stays DROP.
- Minimum fetch latency: request cycle N, rvalid N+1, IF/ID valid at N+2. Sustained throughput is 1 instruction per 2 cycles with zero-wait memory.
- IF/ID update priority per edge: flush_i > stall_i > load > bubble.
  - flush_i: valid<=0, instr<=NOP_INSTR, pc unchanged. A flush is a squash, not a stall, so a concurrent rvalid with stall_i low and no redirect still advances state normally.
  - stall_i: IF/ID unchanged.
  - No load and not stalled: valid<=0, instr<=NOP_INSTR.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
  - redirect_pc_i[1:0] forced to 2'b00 when loaded into pc.
- if_id_opcode_o is purely combinational from the registered if_id_instr_o, never from imem_rdata_i.
- rvalid in REQ state is a protocol error: ignored.
- rst_n assertion mid-transaction aborts immediately. Any in-flight response after reset release is not expected.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - fetch_cnt_o increments on every IF/ID load with valid=1.
  - bubble_cnt_o increments on every edge where IF/ID is written with valid=0 (bubble or flush).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: counters absent; both ports tied to 0.

Test Plan:
- Reset, zero-wait memory returning 32'h0000_0033 for every address:
  - imem_addr_o sequence 0,4,8.
  - if_id_valid_o first high 2 cycles after first grant, with pc=0 and opcode=7'b0110011.
- Redirect in WAIT before rvalid, redirect_pc_i=32'h0000_0102:
  - Late response for the old PC is dropped.
  - Next imem_addr_o=32'h100; IF/ID never shows the dropped word.
- stall_i high for 3 cycles while rvalid arrives with 32'hDEAD_0013:
  - Word held in HOLD; IF/ID unchanged during stall.
  - Word appears in IF/ID the cycle after stall_i falls; no request issued during HOLD.
- flush_i and stall_i together: if_id_valid_o=0 and if_id_instr_o=32'h0000_0013 next cycle.
- PC wrap, RESET_PC=32'hFFFF_FFFC: fetch at FFFF_FFFC, then next imem_addr_o=0.
- FETCH_PERF_CNT_EN on: after 4 delivered instructions and 1 flush, fetch_cnt_o=4 and bubble_cnt_o counts every valid=0 write including the flush. Macro off: both outputs 0.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// rtl/if_id_fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
// Optional fetch/bubble performance counters are enabled by defining FETCH_PERF_CNT_EN.
module if_id_fetch_stage #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [6:0]      if_id_opcode_o,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     bubble_cnt_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] r_hold_pc;
  logic [XLEN-1:0] r_hold_instr;
  logic            w_hold_cap;
  logic            w_load;
  logic [XLEN-1:0] w_load_pc;
  logic [XLEN-1:0] w_load_instr;
  logic            r_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_instr;

  assign w_redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_pc_inc      = r_pc + XLEN'(4);

  // Reset gating keeps the request low while the state register sits in REQ.
  assign imem_req_o  = rst_n && (r_state == S_REQ) && !redirect_i;
  assign imem_addr_o = r_pc;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_hold_cap   = 1'b0;
    w_load       = 1'b0;
    w_load_pc    = r_pc;
    w_load_instr = imem_rdata_i;
    case (r_state)
      S_REQ: begin
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end else if (imem_gnt_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          w_pc_nxt = w_pc_inc;
          if (stall_i) begin
            w_hold_cap  = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_REQ;
        end else if (!stall_i) begin
          w_load       = 1'b1;
          w_load_pc    = r_hold_pc;
          w_load_instr = r_hold_instr;
          w_state_nxt  = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (imem_rvalid_i) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_hold_cap) begin
        r_hold_pc    <= r_pc;
        r_hold_instr <= imem_rdata_i;
      end
    end
  end

  // Flush squashes whatever would have been loaded; stall freezes the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP_INSTR;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_if_instr <= NOP_INSTR;
    end else if (!stall_i) begin
      if (w_load) begin
        r_valid    <= 1'b1;
        r_if_pc    <= w_load_pc;
        r_if_instr <= w_load_instr;
      end else begin
        r_valid    <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end
    end
  end

  assign if_id_valid_o  = r_valid;
  assign if_id_pc_o     = r_if_pc;
  assign if_id_instr_o  = r_if_instr;
  assign if_id_opcode_o = r_if_instr[6:0];

`ifdef FETCH_PERF_CNT_EN
  logic        w_fetch_evt;
  logic        w_bubble_evt;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  assign w_fetch_evt  = !flush_i && w_load;
  assign w_bubble_evt = flush_i || (!stall_i && !w_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_fetch_evt && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_bubble_evt && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o  = r_fetch_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`else
  assign fetch_cnt_o  = 32'd0;
  assign bubble_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb/tb_if_id_fetch_stage.sv - randomized self-checking bench for if_id_fetch_stage
// Directed scenarios plus a random run, all checked against a transaction-level fetch model.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic [6:0]  if_id_opcode_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [31:0] w_fcnt;
  logic [31:0] w_bcnt;

  if_id_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o),
    .if_id_opcode_o(if_id_opcode_o), .fetch_cnt_o(fetch_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_id_valid_o(w_valid), .if_id_pc_o(w_pc), .if_id_instr_o(w_instr),
    .if_id_opcode_o(w_opcode), .fetch_cnt_o(w_fcnt), .bubble_cnt_o(w_bcnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory responder state
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          mem_const_en;
  logic [31:0] mem_const;
  logic [31:0] fire_q[$];

  // reference model: one live fetch, its address, and the architectural IF/ID view
  bit          m_live;
  bit          m_got;
  logic [31:0] m_live_addr;
  logic [31:0] m_next;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int unsigned m_fetch;
  int unsigned m_bubble;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_const_en) return mem_const;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_mem();
    if (pend && pend_wait == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
  endtask

  task automatic tick();
    bit          s_fire, s_resp, s_stall, s_flush, s_redir, deliver, exp_req;
    logic [31:0] s_addr, s_tgt, d_addr;
    drive_mem();
    #1;
    s_fire  = imem_req_o && imem_gnt_i;
    s_addr  = imem_addr_o;
    s_resp  = imem_rvalid_i;
    s_stall = stall_i;
    s_flush = flush_i;
    s_redir = redirect_i;
    s_tgt   = redirect_pc_i;
    exp_req = !s_redir && !m_live && !pend;
    checks++;
    if (imem_req_o !== exp_req) begin
      errors++;
      $display("FAIL imem_req: got %b expected %b at %0t", imem_req_o, exp_req, $time);
    end
    if (s_fire) begin
      checks++;
      if (s_addr !== m_next) begin
        errors++;
        $display("FAIL imem_addr: got %h expected %h at %0t", s_addr, m_next, $time);
      end
      fire_q.push_back(s_addr);
    end
    @(posedge clk);
    if (s_resp) pend = 1'b0;
    else if (pend && pend_wait > 0) pend_wait--;
    if (s_fire) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_wait = int'($urandom_range(lat_hi, lat_lo)) - 1;
    end
    deliver = 1'b0;
    d_addr  = m_live_addr;
    if (s_redir) begin
      m_live = 1'b0;
      m_next = {s_tgt[31:2], 2'b00};
    end else begin
      if (m_live && s_resp) m_got = 1'b1;
      if (m_live && m_got && !s_stall) begin
        deliver = 1'b1;
        m_live  = 1'b0;
      end
    end
    if (s_fire) begin
      m_live      = 1'b1;
      m_got       = 1'b0;
      m_live_addr = m_next;
      m_next      = m_next + 32'd4;
    end
    if (s_flush) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!s_stall) begin
      if (deliver) begin
        m_valid = 1'b1;
        m_pc    = d_addr;
        m_instr = mem_word(d_addr);
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    if (s_flush || (!s_stall && !deliver)) m_bubble++;
    else if (deliver) m_fetch++;
    @(negedge clk);
    checks += 4;
    if (if_id_valid_o !== m_valid) begin
      errors++;
      $display("FAIL if_id_valid: got %b expected %b at %0t", if_id_valid_o, m_valid, $time);
    end
    if (if_id_pc_o !== m_pc) begin
      errors++;
      $display("FAIL if_id_pc: got %h expected %h at %0t", if_id_pc_o, m_pc, $time);
    end
    if (if_id_instr_o !== m_instr) begin
      errors++;
      $display("FAIL if_id_instr: got %h expected %h at %0t", if_id_instr_o, m_instr, $time);
    end
    if (if_id_opcode_o !== m_instr[6:0]) begin
      errors++;
      $display("FAIL if_id_opcode: got %h expected %h at %0t", if_id_opcode_o, m_instr[6:0], $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    pend = 1'b0; lat_lo = 1; lat_hi = 1;
    m_live = 1'b0; m_got = 1'b0; m_live_addr = '0; m_next = 32'h0;
    m_valid = 1'b0; m_pc = '0; m_instr = NOP; m_fetch = 0; m_bubble = 0;
    fire_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    imem_gnt_i = 1'b1;
    @(negedge clk);
    #1;
    checks += 7;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
    if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr_o); end
    if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_wrap_addr: got %h expected fffffffc", w_addr); end
    if (if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h0) begin
      errors++; $display("FAIL rst_ifid: got valid=%b pc=%h expected 0/0", if_id_valid_o, if_id_pc_o);
    end
    if (if_id_instr_o !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", if_id_instr_o, NOP); end
    if (if_id_opcode_o !== 7'h13) begin errors++; $display("FAIL rst_opcode: got %h expected 13", if_id_opcode_o); end
    if (fetch_cnt_o !== 32'd0 || bubble_cnt_o !== 32'd0) begin
      errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", fetch_cnt_o, bubble_cnt_o);
    end
    do_reset();
    #1;
    checks++;
    if (imem_req_o !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %b expected 1", imem_req_o); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] got;
    do_reset();
    mem_const_en = 1'b1; mem_const = 32'h0000_0033; imem_gnt_i = 1'b1;
    tick();
    checks++;
    if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL zw_valid_early: got %b expected 0", if_id_valid_o); end
    tick();
    checks += 2;
    if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0) begin
      errors++; $display("FAIL zw_first: got valid=%b pc=%h expected 1/0", if_id_valid_o, if_id_pc_o);
    end
    if (if_id_opcode_o !== 7'b0110011) begin errors++; $display("FAIL zw_opcode: got %b expected 0110011", if_id_opcode_o); end
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      got = (i < fire_q.size()) ? fire_q[i] : 32'hxxxx_xxxx;
      checks++;
      if (got !== 32'(i * 4)) begin errors++; $display("FAIL zw_addr_seq[%0d]: got %h expected %h", i, got, 32'(i * 4)); end
    end
  endtask

  task automatic test_redirect_wait();
    bit          saw_old;
    logic [31:0] got;
    do_reset();
    mem_const_en = 1'b0; lat_lo = 3; lat_hi = 3; imem_gnt_i = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_i = 1'b0;
    saw_old = 1'b0;
    for (int i = 0; i < 10 && fire_q.size() < 2; i++) begin
      tick();
      if (if_id_valid_o && if_id_pc_o == 32'h0) saw_old = 1'b1;
    end
    got = (fire_q.size() >= 2) ? fire_q[1] : 32'hxxxx_xxxx;
    checks += 2;
    if (got !== 32'h0000_0100) begin errors++; $display("FAIL redir_next_addr: got %h expected 00000100", got); end
    if (saw_old !== 1'b0) begin errors++; $display("FAIL redir_dropped_word: got shown=%b expected 0", saw_old); end
    repeat (3) tick();
  endtask

  task automatic test_stall_hold();
    do_reset();
    mem_const_en = 1'b1; mem_const = 32'hDEAD_0013; imem_gnt_i = 1'b1;
    tick(); tick();
    fire_q.delete();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'hDEAD_0013) begin
        errors++;
        $display("FAIL stall_frozen[%0d]: got %b/%h/%h expected 1/00000000/dead0013",
                 i, if_id_valid_o, if_id_pc_o, if_id_instr_o);
      end
    end
    checks++;
    if (fire_q.size() != 1) begin errors++; $display("FAIL stall_req_count: got %0d expected 1", fire_q.size()); end
    stall_i = 1'b0;
    tick();
    checks++;
    if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h4 || if_id_instr_o !== 32'hDEAD_0013) begin
      errors++;
      $display("FAIL hold_release: got %b/%h/%h expected 1/00000004/dead0013", if_id_valid_o, if_id_pc_o, if_id_instr_o);
    end
  endtask

  task automatic test_flush_stall();
    flush_i = 1'b1; stall_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    checks++;
    if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0000_0013) begin
      errors++; $display("FAIL flush_stall: got %b/%h expected 0/00000013", if_id_valid_o, if_id_instr_o);
    end
    repeat (3) tick();
  endtask

  task automatic test_pc_wrap();
    do_reset();
    mem_const_en = 1'b1; mem_const = 32'h0000_0033; imem_gnt_i = 1'b1;
    #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first: got req=%b addr=%h expected 1/fffffffc", w_req, w_addr);
    end
    tick(); tick();
    checks += 2;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_ifid: got %b/%h expected 1/fffffffc", w_valid, w_pc);
    end
    if (w_req !== 1'b1 || w_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1/00000000", w_req, w_addr);
    end
  endtask

  task automatic test_perf_cnt();
    logic [31:0] exp_f, exp_b;
    do_reset();
    mem_const_en = 1'b1; mem_const = 32'h0000_0033; imem_gnt_i = 1'b1;
    repeat (8) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    exp_f = 32'd4; exp_b = 32'd5;
`else
    exp_f = 32'd0; exp_b = 32'd0;
`endif
    checks += 2;
    if (fetch_cnt_o !== exp_f) begin errors++; $display("FAIL perf_fetch: got %0d expected %0d", fetch_cnt_o, exp_f); end
    if (bubble_cnt_o !== exp_b) begin errors++; $display("FAIL perf_bubble: got %0d expected %0d", bubble_cnt_o, exp_b); end
  endtask

  task automatic test_random();
    logic [31:0] exp_f, exp_b;
    do_reset();
    mem_const_en = 1'b0; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      imem_gnt_i    = ($urandom_range(9, 0) < 7);
      stall_i       = ($urandom_range(9, 0) < 3);
      flush_i       = ($urandom_range(11, 0) == 0);
      redirect_i    = ($urandom_range(13, 0) == 0);
      redirect_pc_i = $urandom;
      tick();
    end
    stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    exp_f = m_fetch; exp_b = m_bubble;
`else
    exp_f = 32'd0; exp_b = 32'd0;
`endif
    checks += 2;
    if (fetch_cnt_o !== exp_f) begin errors++; $display("FAIL rand_fetch_cnt: got %0d expected %0d", fetch_cnt_o, exp_f); end
    if (bubble_cnt_o !== exp_b) begin errors++; $display("FAIL rand_bubble_cnt: got %0d expected %0d", bubble_cnt_o, exp_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_const_en = 1'b0;
    mem_const = '0;
    test_reset();
    test_zero_wait();
    test_redirect_wait();
    test_stall_hold();
    test_flush_stall();
    test_pc_wrap();
    test_perf_cnt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
